rom_copy_engine: RTL and testbench

Parametrised flash-to-SDRAM ROM loader. It copies a programmable window of words from the flash controller's word port into SDRAM through the ROM-load write port. Flash fetches overlap RAM writes through an internal prefetch FIFO. It adds a start trigger, source/destination bases, length, optional byte swap and a running checksum. It sits between the flash controller and the SDRAM arbiter's ROM-load channel.

---
 rtl/rom_copy_pkg.sv | 28 ++
 rtl/rom_copy_fifo.sv | 60 ++++++
 rtl/rom_copy_engine.sv | 186 ++++++++++++++++++
 tb/tb_rom_copy_engine.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_copy_pkg.sv
// Shared types and helpers for the flash-to-SDRAM ROM copy engine.
package rom_copy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_DW        = 16;
    localparam int BYTES_PER_WORD = WORD_DW / 8;
    localparam int MAX_DW         = 64;

    // Reverses the lowest nbytes bytes of d; callers pass a constant nbytes.
    function automatic logic [MAX_DW-1:0] byte_swap(input logic [MAX_DW-1:0] d,
                                                    input int nbytes);
        logic [MAX_DW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DW / 8; i++) begin
            if (i < nbytes) begin
                r[i*8 +: 8] = d[(nbytes-1-i)*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_copy_fifo.sv
// Prefetch FIFO between flash capture and SDRAM write issue.
module rom_copy_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                   iclk,
    input  logic                   ireset_n,
    input  logic                   ipush,
    input  logic                   ipop,
    input  logic [DW-1:0]          idin,
    output logic [DW-1:0]          odout,
    output logic [$clog2(DEPTH):0] ocount,
    output logic                   ofull,
    output logic                   oempty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot that cycle.
    assign w_push = ipush && (!ofull || ipop);
    assign w_pop  = ipop && !oempty;

    always_ff @(posedge iclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= idin;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign odout  = r_mem[r_rptr];
    assign ocount = r_count;
    assign ofull  = (r_count == (AW+1)'(DEPTH));
    assign oempty = (r_count == '0);

endmodule

// File: rtl/rom_copy_engine.sv
// Copies a window of flash words into SDRAM via the ROM-load port, overlapping
// toggle-handshake flash fetches with rate-limited RAM write strobes.
module rom_copy_engine
    import rom_copy_pkg::*;
#(
    parameter int FL_AW      = 23,
    parameter int RAM_AW     = 25,
    parameter int DW         = WORD_DW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              istart,
    input  logic [FL_AW-1:0]  isrc_base,
    input  logic [RAM_AW-1:0] idst_base,
    input  logic [FL_AW:0]    ilen,
    input  logic              iswap,
    output logic              oloading,
    output logic              odone,
    output logic [15:0]       ochecksum,
    output logic [FL_AW-1:0]  ofl_addr,
    input  logic [DW-1:0]     ifl_data,
    output logic              ofl_req,
    input  logic              ifl_ack,
    output logic              orom_load_wr,
    input  logic              irom_load_wait,
    output logic [RAM_AW-1:0] oram_addr,
    output logic [DW-1:0]     oram_wrdata,
    output logic [1:0]        odbg_state
);
    localparam int BPW = DW / 8;
    localparam int LW  = FL_AW + 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    // Flash side: ofl_req toggles to request; the request is complete when
    // ifl_ack equals ofl_req, and ifl_data is valid in that same cycle.
    state_t            r_state;
    state_t            w_state_nxt;
    logic [FL_AW-1:0]  r_src;
    logic [LW-1:0]     r_req_left;
    logic [FL_AW-1:0]  r_fl_addr;
    logic              r_req;
    logic              r_outstanding;
    logic [RAM_AW-1:0] r_dst;
    logic              r_swap;
    logic              r_wr;
    logic [15:0]       r_checksum;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [DW-1:0]     r_wrdata;

    logic              w_ack_match;
    logic              w_capture;
    logic              w_start;
    logic              w_issue;
    logic              w_pop;
    logic [FL_AW-1:0]  w_src_base;
    logic [LW-1:0]     w_left_base;
    logic [DW-1:0]     w_fifo_dout;
    logic [DW-1:0]     w_swapped;
    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_active;

    assign w_ack_match = (ifl_ack == r_req);
    assign w_capture   = r_outstanding && w_ack_match;
    assign w_start     = (r_state == IDLE) && istart;
    assign w_active    = (r_state == RUN) || (r_state == FLUSH);
    assign w_src_base  = w_start ? isrc_base : r_src;
    assign w_left_base = w_start ? ilen : r_req_left;

    // The first request leaves on the start edge so it is visible the next cycle.
    assign w_issue = w_ack_match && !r_outstanding && (w_left_base != '0) &&
                     (w_start || ((r_state == RUN) && !w_fifo_full));

    // One idle cycle after each strobe gives the arbiter time to raise wait.
    assign w_pop = w_active && !w_fifo_empty && !irom_load_wait && !r_wr;

    assign w_swapped = DW'(byte_swap(MAX_DW'(w_fifo_dout), BPW));

    rom_copy_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iclk     (iclk),
        .ireset_n (ireset_n),
        .ipush    (w_capture),
        .ipop     (w_pop),
        .idin     (ifl_data),
        .odout    (w_fifo_dout),
        .ocount   (w_fifo_count),
        .ofull    (w_fifo_full),
        .oempty   (w_fifo_empty)
    );

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (istart) begin
                    w_state_nxt = (ilen == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_capture && (r_req_left == '0)) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if ((w_fifo_count == '0) && !r_wr && !irom_load_wait) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_src         <= '0;
            r_req_left    <= '0;
            r_fl_addr     <= '0;
            r_req         <= 1'b0;
            r_outstanding <= 1'b0;
            r_dst         <= '0;
            r_swap        <= 1'b0;
            r_wr          <= 1'b0;
            r_checksum    <= '0;
            r_ram_addr    <= '0;
            r_wrdata      <= '0;
        end else begin
            r_src      <= w_issue ? (w_src_base + FL_AW'(1)) : w_src_base;
            r_req_left <= w_issue ? (w_left_base - LW'(1)) : w_left_base;
            if (w_issue) begin
                r_fl_addr <= w_src_base;
                r_req     <= ~r_req;
            end
            if (w_issue) begin
                r_outstanding <= 1'b1;
            end else if (w_capture) begin
                r_outstanding <= 1'b0;
            end
            if (w_start) begin
                r_dst  <= idst_base;
                r_swap <= iswap;
            end else if (w_pop) begin
                r_dst <= r_dst + RAM_AW'(BPW);
            end
            r_wr <= w_pop;
            // Checksum covers the raw flash word, independent of byte swap.
            if (w_start) begin
                r_checksum <= '0;
            end else if (w_pop) begin
                r_checksum <= r_checksum + 16'(w_fifo_dout);
            end
            if (w_pop) begin
                r_ram_addr <= r_dst;
                r_wrdata   <= r_swap ? w_swapped : w_fifo_dout;
            end
        end
    end

    assign oloading     = w_active;
    assign odone        = (r_state == DONE);
    assign ochecksum    = r_checksum;
    assign ofl_addr     = r_fl_addr;
    assign ofl_req      = r_req;
    assign orom_load_wr = r_wr;
    assign oram_addr    = r_ram_addr;
    assign oram_wrdata  = r_wrdata;
    assign odbg_state   = r_state;

endmodule

// File: tb/tb_rom_copy_engine.sv
// Directed bench for rom_copy_engine: flash toggle responder, SDRAM wait
// generator, write/request monitor and step-by-step checks.
module tb_rom_copy_engine;

    localparam int FL_AW      = 23;
    localparam int RAM_AW     = 25;
    localparam int DW         = 16;
    localparam int FIFO_DEPTH = 4;

    logic              iclk = 1'b0;
    logic              ireset_n = 1'b0;
    logic              istart = 1'b0;
    logic [FL_AW-1:0]  isrc_base = '0;
    logic [RAM_AW-1:0] idst_base = '0;
    logic [FL_AW:0]    ilen = '0;
    logic              iswap = 1'b0;
    logic              oloading;
    logic              odone;
    logic [15:0]       ochecksum;
    logic [FL_AW-1:0]  ofl_addr;
    logic [DW-1:0]     ifl_data = '0;
    logic              ofl_req;
    logic              ifl_ack = 1'b0;
    logic              orom_load_wr;
    logic              irom_load_wait = 1'b0;
    logic [RAM_AW-1:0] oram_addr;
    logic [DW-1:0]     oram_wrdata;
    logic [1:0]        odbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [RAM_AW-1:0] got_addr_q[$];
    logic [DW-1:0]     got_data_q[$];
    logic [FL_AW-1:0]  got_fl_q[$];
    logic [DW-1:0]     exp_q[$];
    logic [15:0]       fmem [int];

    int   n_done = 0;
    int   fl_cnt = 0;
    int   gap_viol = 0;
    int   wait_viol = 0;
    int   wait_cnt = 0;
    int   fl_lat = 0;
    bit   wait_mode = 1'b0;
    bit   force_wait = 1'b0;
    logic prev_wr = 1'b0;
    logic prev_req = 1'b0;

    rom_copy_engine #(
        .FL_AW      (FL_AW),
        .RAM_AW     (RAM_AW),
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .iclk           (iclk),
        .ireset_n       (ireset_n),
        .istart         (istart),
        .isrc_base      (isrc_base),
        .idst_base      (idst_base),
        .ilen           (ilen),
        .iswap          (iswap),
        .oloading       (oloading),
        .odone          (odone),
        .ochecksum      (ochecksum),
        .ofl_addr       (ofl_addr),
        .ifl_data       (ifl_data),
        .ofl_req        (ofl_req),
        .ifl_ack        (ifl_ack),
        .orom_load_wr   (orom_load_wr),
        .irom_load_wait (irom_load_wait),
        .oram_addr      (oram_addr),
        .oram_wrdata    (oram_wrdata),
        .odbg_state     (odbg_state)
    );

    // ---------------- clock ----------------
    always #5 iclk = ~iclk;

    function automatic logic [15:0] flash_word(input logic [FL_AW-1:0] a);
        if (fmem.exists(int'(a))) return fmem[int'(a)];
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // ---------------- flash responder (2-cycle latency) ----------------
    always @(negedge iclk) begin
        if (!ireset_n) begin
            ifl_ack = 1'b0;
            fl_lat  = 0;
        end else if (ofl_req !== ifl_ack) begin
            if (fl_lat >= 1) begin
                ifl_data = flash_word(ofl_addr);
                ifl_ack  = ofl_req;
                fl_lat   = 0;
                fl_cnt++;
            end else begin
                fl_lat++;
            end
        end
    end

    // ---------------- monitor + SDRAM wait generator ----------------
    always @(negedge iclk) begin
        if (!ireset_n) begin
            prev_wr  = 1'b0;
            prev_req = 1'b0;
            wait_cnt = 0;
        end else begin
            if (orom_load_wr) begin
                got_addr_q.push_back(oram_addr);
                got_data_q.push_back(oram_wrdata);
                if (prev_wr) gap_viol++;
                if (irom_load_wait) wait_viol++;
            end
            if (ofl_req !== prev_req) got_fl_q.push_back(ofl_addr);
            if (odone) n_done++;
            prev_wr  = orom_load_wr;
            prev_req = ofl_req;
            if (orom_load_wr && wait_mode) wait_cnt = 2;
            else if (wait_cnt > 0) wait_cnt--;
        end
        irom_load_wait = force_wait || (wait_cnt > 0);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge iclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_copy(input logic [FL_AW-1:0] src, input logic [RAM_AW-1:0] dst,
                              input int len, input bit swap);
        isrc_base = src;
        idst_base = dst;
        ilen      = (FL_AW+1)'(len);
        iswap     = swap;
        istart    = 1'b1;
        step();
        istart    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            if (odone) seen = 1'b1;
            else step();
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_loading_low_at_done"}, 32'(oloading), 32'd0);
        step();
        check({tag, "_done_one_cycle"}, 32'(odone), 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_copy(input string tag, input int wbase, input int fbase,
                              input logic [FL_AW-1:0] src, input logic [RAM_AW-1:0] dst,
                              input int n, input bit swap);
        logic [FL_AW-1:0]  a;
        logic [RAM_AW-1:0] ea;
        logic [15:0]       d;
        logic [15:0]       sum;
        logic [DW-1:0]     ed;
        sum = '0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            d = flash_word(src + FL_AW'(i));
            sum += d;
            exp_q.push_back(swap ? {d[7:0], d[15:8]} : d);
        end
        check({tag, "_n_writes"}, 32'(got_addr_q.size() - wbase), 32'(n));
        check({tag, "_n_requests"}, 32'(got_fl_q.size() - fbase), 32'(n));
        for (int i = 0; i < n; i++) begin
            a  = src + FL_AW'(i);
            ea = dst + RAM_AW'(2 * i);
            ed = exp_q.pop_front();
            if (wbase + i < got_addr_q.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 32'(got_addr_q[wbase+i]), 32'(ea));
                check($sformatf("%s_data%0d", tag, i), 32'(got_data_q[wbase+i]), 32'(ed));
            end
            if (fbase + i < got_fl_q.size()) begin
                check($sformatf("%s_fladdr%0d", tag, i), 32'(got_fl_q[fbase+i]), 32'(a));
            end
        end
        check({tag, "_checksum"}, 32'(ochecksum), 32'(sum));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        int wbase;
        int fbase;
        int dbase;
        int fcnt0;
        logic req0;
        bit reached;

        fmem[0] = 16'h1234;
        fmem[1] = 16'h5678;
        fmem[2] = 16'h9ABC;
        fmem[3] = 16'hDEF0;

        repeat (3) step();
        check("rst_loading", 32'(oloading), 32'd0);
        check("rst_done", 32'(odone), 32'd0);
        check("rst_wr", 32'(orom_load_wr), 32'd0);
        check("rst_req", 32'(ofl_req), 32'd0);
        check("rst_fl_addr", 32'(ofl_addr), 32'd0);
        check("rst_ram_addr", 32'(oram_addr), 32'd0);
        check("rst_wrdata", 32'(oram_wrdata), 32'd0);
        check("rst_checksum", 32'(ochecksum), 32'd0);
        ireset_n = 1'b1;
        step();

        // 1: basic copy with 2-cycle wait after each strobe
        wait_mode = 1'b1;
        wbase = got_addr_q.size(); fbase = got_fl_q.size(); dbase = n_done;
        start_copy('0, '0, 4, 1'b0);
        check("basic_loading_high", 32'(oloading), 32'd1);
        wait_done("basic", 200);
        check_copy("basic", wbase, fbase, '0, '0, 4, 1'b0);
        check("basic_checksum_E258", 32'(ochecksum), 32'h0000E258);
        check("basic_data0", 32'(got_data_q[wbase]), 32'h00001234);
        check("basic_one_done", 32'(n_done - dbase), 32'd1);

        // 2: byte swap, checksum unaffected
        wbase = got_addr_q.size(); fbase = got_fl_q.size(); dbase = n_done;
        start_copy('0, '0, 4, 1'b1);
        wait_done("swap", 200);
        check_copy("swap", wbase, fbase, '0, '0, 4, 1'b1);
        check("swap_data3", 32'(got_data_q[wbase+3]), 32'h0000F0DE);
        check("swap_checksum_E258", 32'(ochecksum), 32'h0000E258);
        check("swap_one_done", 32'(n_done - dbase), 32'd1);

        // 3: zero length
        wbase = got_addr_q.size(); fcnt0 = fl_cnt; req0 = ofl_req;
        ilen = '0; istart = 1'b1;
        step();
        istart = 1'b0;
        check("zero_done_cycle2", 32'(odone), 32'd1);
        check("zero_checksum_cleared", 32'(ochecksum), 32'd0);
        step();
        check("zero_done_cleared", 32'(odone), 32'd0);
        check("zero_no_req_toggle", 32'(ofl_req), 32'(req0));
        check("zero_no_flash", 32'(fl_cnt - fcnt0), 32'd0);
        check("zero_no_writes", 32'(got_addr_q.size() - wbase), 32'd0);

        // 4: backpressure fills the prefetch FIFO
        wait_mode = 1'b0; force_wait = 1'b1;
        step();
        wbase = got_addr_q.size(); fbase = got_fl_q.size(); fcnt0 = fl_cnt; dbase = n_done;
        start_copy(23'd100, 25'd200, 10, 1'b0);
        repeat (60) step();
        check("bp_flash_stalled_at_4", 32'(fl_cnt - fcnt0), 32'd4);
        check("bp_requests_4", 32'(got_fl_q.size() - fbase), 32'd4);
        check("bp_no_writes", 32'(got_addr_q.size() - wbase), 32'd0);
        force_wait = 1'b0;
        wait_done("bp", 400);
        check_copy("bp", wbase, fbase, 23'd100, 25'd200, 10, 1'b0);
        check("bp_one_done", 32'(n_done - dbase), 32'd1);

        // 5: address wrap on both sides
        wait_mode = 1'b1;
        wbase = got_addr_q.size(); fbase = got_fl_q.size();
        start_copy(23'h7FFFFE, 25'h1FFFFFC, 4, 1'b0);
        wait_done("wrap", 200);
        check_copy("wrap", wbase, fbase, 23'h7FFFFE, 25'h1FFFFFC, 4, 1'b0);
        if (got_fl_q.size() > fbase + 2) check("wrap_fl_zero", 32'(got_fl_q[fbase+2]), 32'd0);
        if (got_addr_q.size() > wbase + 2) check("wrap_ram_zero", 32'(got_addr_q[wbase+2]), 32'd0);

        // 6: reset in the middle of a copy, then restart
        wait_mode = 1'b0;
        wbase = got_addr_q.size(); dbase = n_done;
        start_copy(23'h40, 25'h80, 8, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            if (got_addr_q.size() >= wbase + 2) reached = 1'b1;
            else step();
        end
        check("rstmid_two_writes_seen", 32'(reached), 32'd1);
        ireset_n = 1'b0;
        #1;
        check("rstmid_loading", 32'(oloading), 32'd0);
        check("rstmid_wr", 32'(orom_load_wr), 32'd0);
        check("rstmid_req", 32'(ofl_req), 32'd0);
        check("rstmid_fl_addr", 32'(ofl_addr), 32'd0);
        check("rstmid_ram_addr", 32'(oram_addr), 32'd0);
        check("rstmid_wrdata", 32'(oram_wrdata), 32'd0);
        check("rstmid_checksum", 32'(ochecksum), 32'd0);
        check("rstmid_no_done", 32'(n_done - dbase), 32'd0);
        repeat (3) step();
        ireset_n = 1'b1;
        step();
        wbase = got_addr_q.size(); fbase = got_fl_q.size(); dbase = n_done;
        start_copy(23'h300, 25'h400, 3, 1'b0);
        wait_done("restart", 200);
        check_copy("restart", wbase, fbase, 23'h300, 25'h400, 3, 1'b0);
        check("restart_one_done", 32'(n_done - dbase), 32'd1);

        check("write_gap_violations", 32'(gap_viol), 32'd0);
        check("write_under_wait", 32'(wait_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
